// File: rtl/pwm_pkg.sv
// Shared constants, pin-mode encoding and the duty compare for the PWM output block.
package pwm_pkg;

   localparam int PWM_CNT_W            = 8;
   localparam logic [PWM_CNT_W-1:0] DUTY_FULL = 8'hFF;
   localparam int PWM_PRESCALE_DEFAULT = 13;
   localparam int NUM_PINS             = 16;

   typedef enum logic [1:0] {
      PIN_LOW  = 2'd0,
      PIN_HIGH = 2'd1,
      PIN_PWM  = 2'd2
   } pin_mode_e;

   // Full scale is special-cased so an all-ones duty never dips at cnt == 255.
   function automatic logic pwm_level(input logic [PWM_CNT_W-1:0] cnt,
                                      input logic [PWM_CNT_W-1:0] duty);
      logic lvl;
      if (duty == DUTY_FULL) begin
         lvl = 1'b1;
      end else begin
         lvl = (cnt < duty);
      end
      return lvl;
   endfunction

   function automatic pin_mode_e pin_mode(input logic en_out, input logic en_pwm);
      pin_mode_e mode;
      if (!en_out) begin
         mode = PIN_LOW;
      end else if (en_pwm) begin
         mode = PIN_PWM;
      end else begin
         mode = PIN_HIGH;
      end
      return mode;
   endfunction

endpackage

// File: rtl/pwm_timebase.sv
// PWM timebase: prescaler, 8-bit period counter, wrap flag and registered period_start pulse.
module pwm_timebase
   import pwm_pkg::*;
#(
   parameter int PRESCALE = PWM_PRESCALE_DEFAULT
) (
   input  logic                 clk,
   input  logic                 rst_n,
   output logic [PWM_CNT_W-1:0] cnt,
   output logic                 wrap,
   output logic                 period_start
);

   localparam logic [15:0] PRESC_LAST = 16'(PRESCALE - 1);

   logic [15:0] presc;
   logic        tick;

   assign tick = (presc == PRESC_LAST);
   assign wrap = tick && (cnt == '1);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         presc        <= '0;
         cnt          <= '0;
         period_start <= 1'b0;
      end else begin
         period_start <= (presc == '0) && (cnt == '0);
         if (tick) begin
            presc <= '0;
            cnt   <= cnt + 1'b1;
         end else begin
            presc <= presc + 16'd1;
         end
      end
   end

endmodule

// File: rtl/pwm_peripheral.sv
// 16-pin PWM output block fed by the SPI register file; one shared duty and timebase.
// Define PWM_SYNC_UPDATE_EN to latch a new duty only at the period boundary.
module pwm_peripheral
   import pwm_pkg::*;
#(
   parameter int PRESCALE = PWM_PRESCALE_DEFAULT
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [7:0]          en_reg_out_7_0,
   input  logic [7:0]          en_reg_out_15_8,
   input  logic [7:0]          en_reg_pwm_7_0,
   input  logic [7:0]          en_reg_pwm_15_8,
   input  logic [7:0]          pwm_duty_cycle,
   output logic [NUM_PINS-1:0] pwm_out,
   output logic                period_start
);

   logic [PWM_CNT_W-1:0] cnt;
   logic [PWM_CNT_W-1:0] duty_act;
   logic                 wrap;
   logic [NUM_PINS-1:0]  en_out;
   logic [NUM_PINS-1:0]  en_pwm;
   logic                 pwm_lvl_p0;
   logic [NUM_PINS-1:0]  pin_nxt_p0;

   assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
   assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

   pwm_timebase #(
      .PRESCALE(PRESCALE)
   ) u_timebase (
      .clk          (clk),
      .rst_n        (rst_n),
      .cnt          (cnt),
      .wrap         (wrap),
      .period_start (period_start)
   );

`ifdef PWM_SYNC_UPDATE_EN
   // Shadow loads as cnt wraps 255 -> 0 so a write never cuts a pulse short.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         duty_act <= '0;
      end else if (wrap) begin
         duty_act <= pwm_duty_cycle;
      end
   end
`else
   logic unused_wrap;
   assign unused_wrap = wrap;
   assign duty_act    = pwm_duty_cycle;
`endif

   // Stage 0: compare and per-pin mode select
   assign pwm_lvl_p0 = pwm_level(cnt, duty_act);

   always_comb begin
      pin_nxt_p0 = '0;
      for (int i = 0; i < NUM_PINS; i++) begin
         case (pin_mode(en_out[i], en_pwm[i]))
            PIN_HIGH: pin_nxt_p0[i] = 1'b1;
            PIN_PWM:  pin_nxt_p0[i] = pwm_lvl_p0;
            default:  pin_nxt_p0[i] = 1'b0;
         endcase
      end
   end

   // Stage 1: registered pin drive
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pwm_out <= '0;
      end else begin
         pwm_out <= pin_nxt_p0;
      end
   end

endmodule

// File: tb/tb_pwm_peripheral.sv
// Scoreboard bench for pwm_peripheral: per-period waveform entries plus reset/update edge checks.
module tb_pwm_peripheral;

   localparam int PRESCALE = 13;
   localparam int PERIOD   = PRESCALE * 256;

`ifdef PWM_SYNC_UPDATE_EN
   localparam bit SYNC = 1'b1;
`else
   localparam bit SYNC = 1'b0;
`endif

   logic        clk;
   logic        rst_n;
   logic [7:0]  en_reg_out_7_0;
   logic [7:0]  en_reg_out_15_8;
   logic [7:0]  en_reg_pwm_7_0;
   logic [7:0]  en_reg_pwm_15_8;
   logic [7:0]  pwm_duty_cycle;
   logic [15:0] pwm_out;
   logic        period_start;

   pwm_peripheral #(
      .PRESCALE(PRESCALE)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .en_reg_out_7_0  (en_reg_out_7_0),
      .en_reg_out_15_8 (en_reg_out_15_8),
      .en_reg_pwm_7_0  (en_reg_pwm_7_0),
      .en_reg_pwm_15_8 (en_reg_pwm_15_8),
      .pwm_duty_cycle  (pwm_duty_cycle),
      .pwm_out         (pwm_out),
      .period_start    (period_start)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [15:0] hi_mask;
      logic [15:0] pwm_mask;
      int          pwm_hi;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   periods_done = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, got, want);
      end
   endtask

   // Monitor: one expected entry is consumed per full period, bounded by period_start pulses
   exp_t        cur;
   bit          measuring;
   int          k, n_bad, bad_k;
   logic [15:0] bad_got, bad_exp, expw;

   always @(negedge clk) begin
      if (period_start === 1'b1 && measuring) begin
         check({cur.name, " period length"}, k, PERIOD);
         check($sformatf("%s waveform bad cycles (first at %0d got %h want %h)",
                         cur.name, bad_k, bad_got, bad_exp), n_bad, 0);
         measuring = 1'b0;
         periods_done++;
      end
      if (period_start === 1'b1 && !measuring && sb_q.size() > 0) begin
         cur       = sb_q.pop_front();
         measuring = 1'b1;
         k         = 0;
         n_bad     = 0;
         bad_k     = -1;
         bad_got   = '0;
         bad_exp   = '0;
      end
      if (measuring) begin
         expw = cur.hi_mask | ((k < cur.pwm_hi) ? cur.pwm_mask : 16'h0000);
         if (pwm_out !== expw) begin
            if (n_bad == 0) begin
               bad_k   = k;
               bad_got = pwm_out;
               bad_exp = expw;
            end
            n_bad++;
         end
         k++;
      end
   end

   task automatic set_cfg(input logic [15:0] eo, input logic [15:0] ep, input logic [7:0] d);
      en_reg_out_7_0  = eo[7:0];
      en_reg_out_15_8 = eo[15:8];
      en_reg_pwm_7_0  = ep[7:0];
      en_reg_pwm_15_8 = ep[15:8];
      pwm_duty_cycle  = d;
   endtask

   task automatic wait_ps(input string name);
      bit found = 1'b0;
      for (int c = 0; c < 2 * PERIOD && !found; c++) begin
         @(negedge clk);
         if (period_start === 1'b1) found = 1'b1;
      end
      check({name, " period_start seen"}, found, 1'b1);
   endtask

   task automatic wait_done(input string name, input int target);
      bit done = 1'b0;
      for (int c = 0; c < 3 * PERIOD && !done; c++) begin
         @(negedge clk);
         if (periods_done >= target) done = 1'b1;
      end
      check({name, " scoreboard drained"}, done, 1'b1);
      if (!done) sb_q.delete();
   endtask

   // Change config mid-period, then expect n clean periods with the given high time
   task automatic run_row(input string name, input logic [15:0] eo, input logic [15:0] ep,
                          input logic [7:0] d, input int hi, input int n);
      int target;
      repeat (100) @(negedge clk);
      set_cfg(eo, ep, d);
      for (int i = 0; i < n; i++) sb_q.push_back('{name, eo & ~ep, eo & ep, hi});
      target = periods_done + n;
      wait_done(name, target);
   endtask

   initial begin
      int target;
      rst_n = 1'b0;
      set_cfg(16'hFFFF, 16'hFFFF, 8'hFF);

      repeat (5) begin
         @(negedge clk);
         check("reset pwm_out", pwm_out, 16'h0000);
         check("reset period_start", period_start, 1'b0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      check("release period_start", period_start, 1'b1);
      check("release pwm_out", pwm_out, SYNC ? 16'h0000 : 16'hFFFF);
      @(negedge clk);
      check("period_start single pulse", period_start, 1'b0);

      run_row("static A5A5", 16'hA5A5, 16'h0000, 8'h40, 0, 2);
      run_row("duty 80 all pwm", 16'hFFFF, 16'hFFFF, 8'h80, 1664, 1);
      run_row("duty 00", 16'hFFFF, 16'hFFFF, 8'h00, 0, 1);
      run_row("duty FF pins 15:12 disabled", 16'h0FFF, 16'hFFFF, 8'hFF, PERIOD, 1);
      run_row("duty 01 pins 15:8 static", 16'hFFFF, 16'h00FF, 8'h01, 13, 1);

      // Duty change 0x20 -> 0xC0 written while cnt moves to 0x50
      set_cfg(16'hFFFF, 16'hFFFF, 8'h20);
      wait_ps("duty 20 setup");
      repeat (1039) @(negedge clk);
      check("duty 20 low before write", pwm_out, 16'h0000);
      pwm_duty_cycle = 8'hC0;
      @(negedge clk);
      check("duty C0 one clk after write", pwm_out, SYNC ? 16'h0000 : 16'hFFFF);
      repeat (960) @(negedge clk);
      check("duty C0 at cnt 0x99", pwm_out, SYNC ? 16'h0000 : 16'hFFFF);
      sb_q.push_back('{"duty C0 next period", 16'h0000, 16'hFFFF, 192 * PRESCALE});
      target = periods_done + 1;
      wait_done("duty C0 next period", target);

      // Reset landing at cnt 0x77 with duty 0x80
      set_cfg(16'hFFFF, 16'hFFFF, 8'h80);
      wait_ps("mid reset setup");
      repeat (1547) @(negedge clk);
      check("pre-reset level at cnt 0x77", pwm_out, 16'hFFFF);
      rst_n = 1'b0;
      @(negedge clk);
      check("mid reset pwm_out", pwm_out, 16'h0000);
      check("mid reset period_start", period_start, 1'b0);
      sb_q.push_back('{"first period after reset", 16'h0000, 16'hFFFF, SYNC ? 0 : 1664});
      target = periods_done + 1;
      rst_n = 1'b1;
      @(negedge clk);
      check("restart period_start", period_start, 1'b1);
      check("restart pwm_out", pwm_out, SYNC ? 16'h0000 : 16'hFFFF);
      wait_done("first period after reset", target);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
